// File: rtl/tlul_adapter_reg_pipe_if.sv
// TL-UL A/D channel bundle (32-bit data, 8-bit source) between a crossbar port
// and a device-side adapter.
interface tlul_adapter_reg_pipe_if;
    // A channel (host -> device)
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_user_parity_en;
    logic        a_ready;

    // D channel (device -> host)
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_user;
    logic        d_error;
    logic        d_ready;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_mask, a_data, a_user_parity_en, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_data, d_user, d_error
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_mask, a_data, a_user_parity_en, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_data, d_user, d_error
    );
endinterface

// File: rtl/tlul_adapter_reg_pipe.sv
// TL-UL device adapter to a single-access register port with a variable-latency
// ack, an ack timeout, and a response FIFO decoupling D-channel backpressure.
module tlul_adapter_reg_pipe #(
    parameter int RegAw         = 8,
    parameter int RegDw         = 32,
    parameter int RspDepth      = 2,
    parameter int TimeoutCycles = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    tlul_adapter_reg_pipe_if.slave tl,
    output logic                   re_o,
    output logic                   we_o,
    output logic [RegAw-1:0]       addr_o,
    output logic [RegDw-1:0]       wdata_o,
    output logic [RegDw/8-1:0]     be_o,
    input  logic [RegDw-1:0]       rdata_i,
    input  logic                   ack_i,
    input  logic                   error_i,
    output logic                   timeout_o
);

    localparam int TlDw = 32;

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;
    localparam logic [2:0] OpAccessAck  = 3'd0;
    localparam logic [2:0] OpAccessAckD = 3'd1;

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StWaitAck = 1'b1;

    localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int CntW = $clog2(RspDepth + 1);
    localparam int TmrW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    localparam logic [PtrW-1:0] PtrLast   = PtrW'(RspDepth - 1);
    localparam logic [CntW-1:0] CntFull   = CntW'(RspDepth);
    localparam logic [TmrW-1:0] TmrLast   = TmrW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam bit              TimeoutEn = (TimeoutCycles != 0);

    if (RegDw != TlDw) begin : g_bad_dw
        $error("tlul_adapter_reg_pipe: RegDw must equal the TL-UL data width (32)");
    end
    if (RspDepth < 1) begin : g_bad_depth
        $error("tlul_adapter_reg_pipe: RspDepth must be at least 1");
    end

    typedef struct packed {
        logic [2:0]      opcode;
        logic [1:0]      size;
        logic [7:0]      source;
        logic [TlDw-1:0] data;
        logic            error;
    } rsp_t;

    // Protocol-level request checks: size/alignment, mask inside the
    // addressed lanes, and full mask for PutFullData.
    function automatic logic tl_req_err(input logic [2:0] op,
                                        input logic [1:0] size,
                                        input logic [1:0] addr_lo,
                                        input logic [3:0] mask);
        logic [3:0] exp_mask;
        logic       align_ok;
        case (size)
            2'd0: begin
                exp_mask = 4'b0001 << addr_lo;
                align_ok = 1'b1;
            end
            2'd1: begin
                exp_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
                align_ok = ~addr_lo[0];
            end
            2'd2: begin
                exp_mask = 4'b1111;
                align_ok = (addr_lo == 2'b00);
            end
            default: begin
                exp_mask = 4'b0000;
                align_ok = 1'b0;
            end
        endcase
        return !align_ok
            || ((mask & ~exp_mask) != 4'b0000)
            || ((op == OpPutFull) && (mask != exp_mask));
    endfunction

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    logic [0:0]      state_q, state_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    rsp_t            mem_q [RspDepth];

    logic            pend_get_q;
    logic [1:0]      pend_size_q;
    logic [7:0]      pend_src_q;

    logic            is_get, is_put, err_int;
    logic            a_ready, a_ack;
    logic            push, pop, fifo_empty, latch_req;
    rsp_t            push_rsp, head_rsp;
    logic            unused_tl;

    assign is_get  = (tl.a_opcode == OpGet);
    assign is_put  = (tl.a_opcode == OpPutFull) || (tl.a_opcode == OpPutPartial);
    assign err_int = tl.a_user_parity_en
                   | tl_req_err(tl.a_opcode, tl.a_size, tl.a_address[1:0], tl.a_mask)
                   | ~(is_get | is_put);

    // Reset gating keeps the A channel closed while the FIFO is being flushed.
    assign a_ready    = !rst_i && (state_q == StIdle) && (count_q < CntFull);
    assign a_ack      = tl.a_valid & a_ready;
    assign tl.a_ready = a_ready;

    assign re_o    = a_ack & ~err_int & is_get;
    assign we_o    = a_ack & ~err_int & is_put;
    assign addr_o  = tl.a_address[RegAw-1:0];
    assign wdata_o = tl.a_data;
    assign be_o    = tl.a_mask;

    assign unused_tl = ^{tl.a_param, tl.a_address};

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        push      = 1'b0;
        push_rsp  = '0;
        latch_req = 1'b0;
        timeout_o = 1'b0;
        case (state_q)
            StIdle: begin
                if (a_ack) begin
                    push_rsp.opcode = is_get ? OpAccessAckD : OpAccessAck;
                    push_rsp.size   = tl.a_size;
                    push_rsp.source = tl.a_source;
                    if (err_int) begin
                        push           = 1'b1;
                        push_rsp.error = 1'b1;
                    end else if (ack_i) begin
                        push           = 1'b1;
                        push_rsp.data  = is_get ? rdata_i : '0;
                        push_rsp.error = error_i;
                    end else begin
                        latch_req = 1'b1;
                        tmr_d     = '0;
                        state_d   = StWaitAck;
                    end
                end
            end
            StWaitAck: begin
                tmr_d           = tmr_q + TmrW'(1);
                push_rsp.opcode = pend_get_q ? OpAccessAckD : OpAccessAck;
                push_rsp.size   = pend_size_q;
                push_rsp.source = pend_src_q;
                // A coincident ack outranks the timeout.
                if (ack_i) begin
                    push           = 1'b1;
                    push_rsp.data  = pend_get_q ? rdata_i : '0;
                    push_rsp.error = error_i;
                    state_d        = StIdle;
                end else if (TimeoutEn && (tmr_q == TmrLast)) begin
                    push           = 1'b1;
                    push_rsp.error = 1'b1;
                    timeout_o      = 1'b1;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (latch_req) begin
            pend_get_q  <= is_get;
            pend_size_q <= tl.a_size;
            pend_src_q  <= tl.a_source;
        end
    end

    // Response FIFO; acceptance already reserved the slot, so push never sees full.
    assign fifo_empty = (count_q == '0);
    assign pop        = ~fifo_empty & tl.d_ready;
    assign head_rsp   = mem_q[rptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
            if (push && !pop)      count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= push_rsp;
    end

    assign tl.d_valid  = ~fifo_empty;
    assign tl.d_opcode = head_rsp.opcode;
    assign tl.d_param  = 3'd0;
    assign tl.d_size   = head_rsp.size;
    assign tl.d_source = head_rsp.source;
    assign tl.d_sink   = 1'b0;
    assign tl.d_data   = head_rsp.data;
    assign tl.d_user   = 1'b0;
    assign tl.d_error  = head_rsp.error;

endmodule

// File: tb/tb_tlul_adapter_reg_pipe.sv
// Directed bench for tlul_adapter_reg_pipe: zero/late ack, timeout, FIFO
// backpressure, request errors and reset during an access.
module tb_tlul_adapter_reg_pipe;
    localparam logic [2:0] OP_GET  = 3'd4;
    localparam logic [2:0] OP_PUTF = 3'd0;
    localparam logic [2:0] OP_PUTP = 3'd1;
    localparam logic [2:0] OP_ACK  = 3'd0;
    localparam logic [2:0] OP_ACKD = 3'd1;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        re_o, we_o, ack_i, error_i, timeout_o;
    logic [7:0]  addr_o;
    logic [31:0] wdata_o, rdata_i;
    logic [3:0]  be_o;
    int          checks = 0;
    int          errors = 0;

    tlul_adapter_reg_pipe_if tl();

    tlul_adapter_reg_pipe #(
        .RegAw(8), .RegDw(32), .RspDepth(2), .TimeoutCycles(8)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .tl(tl),
        .re_o(re_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .be_o(be_o), .rdata_i(rdata_i), .ack_i(ack_i), .error_i(error_i),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [2:0] op, input logic [7:0] src,
                           input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] data, input logic par);
        tl.a_valid          = v;
        tl.a_opcode         = op;
        tl.a_param          = 3'd0;
        tl.a_size           = 2'd2;
        tl.a_source         = src;
        tl.a_address        = addr;
        tl.a_mask           = mask;
        tl.a_data           = data;
        tl.a_user_parity_en = par;
    endtask

    task automatic a_idle();
        drive_a(1'b0, OP_GET, 8'h00, 32'h0, 4'hF, 32'h0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; ack_i = 1'b0; error_i = 1'b0; rdata_i = 32'h0;
        tl.d_ready = 1'b0;
        drive_a(1'b1, OP_GET, 8'h00, 32'h0, 4'hF, 32'h0, 1'b0);
        #2;
        chk("rst_a_ready", tl.a_ready === 1'b0);
        chk("rst_d_valid", tl.d_valid === 1'b0);
        chk("rst_re", re_o === 1'b0);
        chk("rst_we", we_o === 1'b0);
        chk("rst_timeout", timeout_o === 1'b0);
        cyc(); cyc();
        rst_i = 1'b0;
        a_idle();
        #1;
        chk("post_rst_a_ready", tl.a_ready === 1'b1);
        chk("post_rst_d_valid", tl.d_valid === 1'b0);

        // Back-to-back Gets with zero-cycle ack
        tl.d_ready = 1'b1; ack_i = 1'b1; error_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_a(1'b1, OP_GET, 8'(k), 32'(4 * k), 4'hF, 32'h0, 1'b0);
            rdata_i = 32'hA000_0000 + 32'(k);
            #1;
            chk("t1_a_ready", tl.a_ready === 1'b1);
            chk("t1_re", re_o === 1'b1);
            chk("t1_we", we_o === 1'b0);
            chk("t1_addr", addr_o === 8'(4 * k));
            if (k > 0) begin
                chk("t1_d_valid", tl.d_valid === 1'b1);
                chk("t1_d_data", tl.d_data === 32'hA000_0000 + 32'(k - 1));
                chk("t1_d_src", tl.d_source === 8'(k - 1));
                chk("t1_d_op", tl.d_opcode === OP_ACKD);
            end else begin
                chk("t1_d_valid0", tl.d_valid === 1'b0);
            end
            cyc();
        end
        a_idle(); ack_i = 1'b0;
        #1;
        chk("t1_last_valid", tl.d_valid === 1'b1);
        chk("t1_last_data", tl.d_data === 32'hA000_0003);
        chk("t1_last_err", tl.d_error === 1'b0);
        cyc();
        chk("t1_drained", tl.d_valid === 1'b0);

        // Write acked 5 cycles later with error
        drive_a(1'b1, OP_PUTF, 8'h05, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
        #1;
        chk("t2_we", we_o === 1'b1);
        chk("t2_re", re_o === 1'b0);
        chk("t2_wdata", wdata_o === 32'hDEAD_BEEF);
        chk("t2_be", be_o === 4'hF);
        chk("t2_addr", addr_o === 8'h10);
        cyc();
        a_idle();
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) begin ack_i = 1'b1; error_i = 1'b1; end
            #1;
            chk("t2_wait_a_ready", tl.a_ready === 1'b0);
            chk("t2_wait_d_valid", tl.d_valid === 1'b0);
            chk("t2_wait_we", we_o === 1'b0);
            cyc();
        end
        ack_i = 1'b0; error_i = 1'b0;
        #1;
        chk("t2_d_valid", tl.d_valid === 1'b1);
        chk("t2_d_op", tl.d_opcode === OP_ACK);
        chk("t2_d_err", tl.d_error === 1'b1);
        chk("t2_d_src", tl.d_source === 8'h05);
        chk("t2_d_data", tl.d_data === 32'h0);
        chk("t2_a_ready", tl.a_ready === 1'b1);
        cyc();
        chk("t2_drained", tl.d_valid === 1'b0);

        // Get never acked: timeout after 8 cycles, late ack dropped
        drive_a(1'b1, OP_GET, 8'h09, 32'h20, 4'hF, 32'h0, 1'b0);
        rdata_i = 32'h5555_AAAA;
        #1;
        chk("t3_re", re_o === 1'b1);
        cyc();
        a_idle();
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("t3_timeout", timeout_o === (i == 8));
            chk("t3_wait_d_valid", tl.d_valid === 1'b0);
            cyc();
        end
        #1;
        chk("t3_d_valid", tl.d_valid === 1'b1);
        chk("t3_d_op", tl.d_opcode === OP_ACKD);
        chk("t3_d_err", tl.d_error === 1'b1);
        chk("t3_d_data", tl.d_data === 32'h0);
        chk("t3_d_src", tl.d_source === 8'h09);
        chk("t3_timeout_clr", timeout_o === 1'b0);
        chk("t3_a_ready", tl.a_ready === 1'b1);
        cyc(); cyc(); cyc();
        ack_i = 1'b1; rdata_i = 32'h1234_5678;
        #1;
        chk("t3_late_re", re_o === 1'b0);
        chk("t3_late_timeout", timeout_o === 1'b0);
        cyc();
        ack_i = 1'b0;
        #1;
        chk("t3_late_dropped", tl.d_valid === 1'b0);

        // Backpressure: two slots, third Put waits for a drain
        tl.d_ready = 1'b0; ack_i = 1'b1;
        drive_a(1'b1, OP_PUTP, 8'h01, 32'h30, 4'h3, 32'h11, 1'b0);
        #1;
        chk("t4_a_ready1", tl.a_ready === 1'b1);
        chk("t4_we1", we_o === 1'b1);
        cyc();
        drive_a(1'b1, OP_PUTP, 8'h02, 32'h34, 4'h3, 32'h22, 1'b0);
        #1;
        chk("t4_a_ready2", tl.a_ready === 1'b1);
        cyc();
        drive_a(1'b1, OP_PUTP, 8'h03, 32'h38, 4'h3, 32'h33, 1'b0);
        #1;
        chk("t4_full_a_ready", tl.a_ready === 1'b0);
        chk("t4_full_we", we_o === 1'b0);
        cyc();
        #1;
        chk("t4_still_full", tl.a_ready === 1'b0);
        chk("t4_head1", tl.d_source === 8'h01);
        tl.d_ready = 1'b1;
        cyc();
        #1;
        chk("t4_a_ready_back", tl.a_ready === 1'b1);
        chk("t4_we3", we_o === 1'b1);
        chk("t4_head2", tl.d_source === 8'h02);
        cyc();
        a_idle(); ack_i = 1'b0;
        #1;
        chk("t4_head3", tl.d_source === 8'h03);
        chk("t4_head3_op", tl.d_opcode === OP_ACK);
        cyc();
        chk("t4_drained", tl.d_valid === 1'b0);

        // Parity-flagged Get: no strobe, error response
        drive_a(1'b1, OP_GET, 8'h07, 32'h40, 4'hF, 32'h0, 1'b1);
        ack_i = 1'b1; rdata_i = 32'hCAFE_F00D;
        #1;
        chk("t5_re", re_o === 1'b0);
        chk("t5_a_ready", tl.a_ready === 1'b1);
        cyc();
        a_idle(); ack_i = 1'b0;
        #1;
        chk("t5_d_valid", tl.d_valid === 1'b1);
        chk("t5_d_op", tl.d_opcode === OP_ACKD);
        chk("t5_d_err", tl.d_error === 1'b1);
        chk("t5_d_data", tl.d_data === 32'h0);
        chk("t5_d_src", tl.d_source === 8'h07);
        cyc();

        // PutFullData with a partial mask is a protocol error
        drive_a(1'b1, OP_PUTF, 8'h06, 32'h44, 4'h3, 32'h55, 1'b0);
        #1;
        chk("t5b_we", we_o === 1'b0);
        cyc();
        a_idle();
        #1;
        chk("t5b_d_op", tl.d_opcode === OP_ACK);
        chk("t5b_d_err", tl.d_error === 1'b1);
        cyc();

        // Reset while waiting for ack with one queued response
        tl.d_ready = 1'b0; ack_i = 1'b1;
        drive_a(1'b1, OP_PUTF, 8'h01, 32'h50, 4'hF, 32'h66, 1'b0);
        #1;
        chk("t6_we", we_o === 1'b1);
        cyc();
        ack_i = 1'b0;
        drive_a(1'b1, OP_GET, 8'h02, 32'h54, 4'hF, 32'h0, 1'b0);
        #1;
        chk("t6_re", re_o === 1'b1);
        chk("t6_queued", tl.d_valid === 1'b1);
        cyc();
        drive_a(1'b1, OP_GET, 8'h03, 32'h58, 4'hF, 32'h0, 1'b0);
        #1;
        chk("t6_wait_a_ready", tl.a_ready === 1'b0);
        rst_i = 1'b1;
        #1;
        chk("t6_rst_d_valid", tl.d_valid === 1'b0);
        chk("t6_rst_a_ready", tl.a_ready === 1'b0);
        chk("t6_rst_re", re_o === 1'b0);
        cyc();
        chk("t6_rst2_d_valid", tl.d_valid === 1'b0);
        chk("t6_rst2_a_ready", tl.a_ready === 1'b0);
        rst_i = 1'b0;
        a_idle(); ack_i = 1'b1;
        #1;
        chk("t6_post_re", re_o === 1'b0);
        chk("t6_post_we", we_o === 1'b0);
        cyc();
        ack_i = 1'b0;
        #1;
        chk("t6_clean_d_valid", tl.d_valid === 1'b0);
        chk("t6_clean_a_ready", tl.a_ready === 1'b1);
        chk("t6_clean_timeout", timeout_o === 1'b0);
        tl.d_ready = 1'b1; ack_i = 1'b1; rdata_i = 32'hB0B0_0001;
        drive_a(1'b1, OP_GET, 8'h04, 32'h5C, 4'hF, 32'h0, 1'b0);
        #1;
        chk("t6_new_re", re_o === 1'b1);
        cyc();
        a_idle(); ack_i = 1'b0;
        #1;
        chk("t6_new_d_valid", tl.d_valid === 1'b1);
        chk("t6_new_d_data", tl.d_data === 32'hB0B0_0001);
        chk("t6_new_d_src", tl.d_source === 8'h04);
        cyc();
        chk("t6_new_drained", tl.d_valid === 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
